axi_mag_squelch_gain: RTL
=========================

// Module: axi_mag_squelch_gain
// PURPOSE
//  Parametrised magnitude-path stage for the magphase RFNoC blocks: unsigned magnitude stream in,
//  squelched and gain-scaled magnitude out. Squelch has separate open/close thresholds plus a hang
//  timer. Gain is fixed-point, with rounding and saturation. Sits between the CORDIC mag/phase splitter
//  and the axi_wrapper source port. Configured via settings bus.
// PARAMETERS
//  WIDTH_IN   16  magnitude input width, unsigned
//  WIDTH_OUT  16  output width; result saturates to 2^(WIDTH_OUT-1)-1 so it packs as signed I of SC16
//  WIDTH_GAIN 16  gain word width, unsigned
//  GAIN_FRAC  12  fractional bits of gain (unity = 1<<GAIN_FRAC)
//  HANG_W     16  hang counter width
//  SR_BASE    192 base settings address; regs at +0 gain, +1 open_lvl, +2 close_lvl, +3 hang_len, +4 ctrl
// PORTS
//  clk          in   1           compute-engine clock
//  reset_n      in   1           asynchronous active-low reset
//  clear        in   1           synchronous flush: FSM->CLOSED, pipeline emptied, counter zeroed
//  set_stb      in   1           settings strobe
//  set_addr     in   8           settings address
//  set_data     in   32          settings data
//  i_tdata      in   WIDTH_IN    magnitude sample
//  i_tlast      in   1           end of packet
//  i_tvalid     in   1           input valid
//  i_tready     out  1           input ready
//  o_tdata      out  WIDTH_OUT   gated, scaled magnitude
//  o_tlast      out  1           i_tlast delayed by the pipeline
//  o_tvalid     out  1           output valid
//  o_tready     in   1           output ready
//  sq_open      out  1           registered: FSM state != CLOSED
//  open_count   out  16          CLOSED->OPEN transitions; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (reset_n=0, async)
//   - Outputs: o_tvalid=0, o_tdata=0, o_tlast=0, sq_open=0, open_count=0.
//   - Regs: gain=1<<GAIN_FRAC, open_lvl=0, close_lvl=0, hang_len=0, ctrl=0.
//   - ctrl bit0 = squelch_en; bit1 = count_clr (self-clearing pulse).
//  Settings
//   - Decoded on set_stb && set_addr==SR_BASE+n; low bits of set_data used.
//   - A write takes effect for the first sample accepted after the strobe cycle.
//  Pipeline
//   - 3 stages: S1 squelch decision + gate; S2 multiply; S3 round/saturate.
//   - Each stage advances when its output is empty or downstream accepts.
//   - i_tready = ~S1_valid | S1_advance. Full throughput (1 sample/clk) when o_tready=1.
//   - Latency: 3 clk from input handshake to o_tvalid.
//   - o_tdata/o_tlast stable while o_tvalid && !o_tready. No combinational path i_tvalid->o_tvalid.
//  Squelch FSM (evaluated once per accepted input sample m)
//   - CLOSED: m>=open_lvl -> OPEN, open_count++.
//   - OPEN:   m<close_lvl -> HANG, cnt=hang_len; if hang_len==0 -> CLOSED instead.
//   - HANG:   m>=close_lvl -> OPEN (open_count unchanged);
//             else if cnt==1 -> CLOSED; else cnt--.
//   - Gating: sample passes iff next_state!=CLOSED; otherwise S1 forces data to 0. tlast always preserved.
//   - squelch_en=0: FSM held in CLOSED, all samples pass, open_count frozen.
//   - open_lvl<close_lvl is legal; behaviour follows the rules above literally.
//  Arithmetic
//   - p = m_gated * gain (WIDTH_IN+WIDTH_GAIN bits).
//   - r = (p + (1<<(GAIN_FRAC-1))) >> GAIN_FRAC (round half up).
//   - o = min(r, 2^(WIDTH_OUT-1)-1).
//  Boundaries
//   - clear and input handshake in the same cycle: clear wins, sample discarded.
//   - count_clr and an increment in the same cycle: result = 0.
//   - Reset mid-packet: all in-flight samples lost; downstream must resync on the next tlast.
//   - Backpressure in HANG: the counter only moves on accepted samples, never on idle cycles.
// STRUCTURE
//  - Shared include magphase_defs.vh: SR offsets, ctrl bit indices, FSM encodings
//    (CLOSED=2'd0, OPEN=2'd1, HANG=2'd2).
//  - One sub-module: squelch_hang_fsm (state, hang counter, gate, open pulse).
//  - Multiply and round/saturate stay inline in the top.
// TESTING
//  1 Reset defaults, en=0, input 1000,40000,0 -> output 1000,32767,0; latency 3; sq_open=0.
//  2 gain=0x2000 (2.0), en=0, input 0x3FFF -> 0x7FFE; input 0x4000 -> saturates to 0x7FFF.
//  3 en=1, open=500, close=300, hang=2; input 100,600,400,200,250,310,100,100,100
//      -> output 0,600,400,200,250,310,100,100,0; open_count=1.
//  4 en=1, hang=0, open=close=500; input 600,499 -> output 600,0.
//  5 Random o_tready at 30% duty over 1000 samples -> output matches model, no drop/dup, tlast aligned.
//  6 clear asserted mid-HANG with 2 samples in flight -> pipeline empty; next sample below open_lvl -> 0.

Source files
------------

// File: rtl/axi_mag_squelch_gain_pkg.sv
// Shared settings offsets, ctrl bit positions and squelch state encodings
// for the magphase magnitude path.
package axi_mag_squelch_gain_pkg;

    localparam int SR_GAIN  = 0;
    localparam int SR_OPEN  = 1;
    localparam int SR_CLOSE = 2;
    localparam int SR_HANG  = 3;
    localparam int SR_CTRL  = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CNT_CLR = 1;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_HANG   = 2'd2
    } sq_state_t;

endpackage

// File: rtl/axi_mag_squelch_gain_fsm.sv
// Squelch state machine with open/close hysteresis and a hang timer that
// only moves on accepted samples.
module squelch_hang_fsm
    import axi_mag_squelch_gain_pkg::*;
#(
    parameter int WIDTH_IN = 16,
    parameter int HANG_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_clear,
    input  logic                i_en,
    input  logic                i_step,
    input  logic [WIDTH_IN-1:0] i_mag,
    input  logic [WIDTH_IN-1:0] i_open_lvl,
    input  logic [WIDTH_IN-1:0] i_close_lvl,
    input  logic [HANG_W-1:0]   i_hang_len,
    output logic                o_pass,
    output logic                o_open_pulse,
    output logic                o_sq_open
);

    sq_state_t         r_state;
    sq_state_t         w_state;
    logic [HANG_W-1:0] r_cnt;
    logic [HANG_W-1:0] w_cnt;

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        o_open_pulse = 1'b0;
        if (!i_en) begin
            w_state = ST_CLOSED;
        end else if (i_step) begin
            unique case (r_state)
                ST_CLOSED: begin
                    if (i_mag >= i_open_lvl) begin
                        w_state      = ST_OPEN;
                        o_open_pulse = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (i_mag < i_close_lvl) begin
                        if (i_hang_len == '0) begin
                            w_state = ST_CLOSED;
                        end else begin
                            w_state = ST_HANG;
                            w_cnt   = i_hang_len;
                        end
                    end
                end
                ST_HANG: begin
                    if (i_mag >= i_close_lvl) begin
                        w_state = ST_OPEN;
                    end else if (r_cnt == HANG_W'(1)) begin
                        w_state = ST_CLOSED;
                    end else begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end
                default: w_state = ST_CLOSED;
            endcase
        end
        // With squelch disabled everything passes.
        o_pass = !i_en || (w_state != ST_CLOSED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLOSED;
            r_cnt     <= '0;
            o_sq_open <= 1'b0;
        end else if (i_clear) begin
            r_state   <= ST_CLOSED;
            r_cnt     <= '0;
            o_sq_open <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            o_sq_open <= (w_state != ST_CLOSED);
        end
    end

endmodule

// File: rtl/axi_mag_squelch_gain.sv
// Magnitude stream squelch + fixed-point gain: S1 gate, S2 multiply,
// S3 round half up and saturate to the positive signed range.
module axi_mag_squelch_gain
    import axi_mag_squelch_gain_pkg::*;
#(
    parameter int WIDTH_IN   = 16,
    parameter int WIDTH_OUT  = 16,
    parameter int WIDTH_GAIN = 16,
    parameter int GAIN_FRAC  = 12,
    parameter int HANG_W     = 16,
    parameter int SR_BASE    = 192
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [WIDTH_IN-1:0]  i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH_OUT-1:0] o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 sq_open,
    output logic [15:0]          open_count
);

    localparam int PW = WIDTH_IN + WIDTH_GAIN;
    localparam logic [7:0] A_GAIN  = 8'(SR_BASE + SR_GAIN);
    localparam logic [7:0] A_OPEN  = 8'(SR_BASE + SR_OPEN);
    localparam logic [7:0] A_CLOSE = 8'(SR_BASE + SR_CLOSE);
    localparam logic [7:0] A_HANG  = 8'(SR_BASE + SR_HANG);
    localparam logic [7:0] A_CTRL  = 8'(SR_BASE + SR_CTRL);
    localparam logic [PW:0] HALF = (PW+1)'(1) << (GAIN_FRAC - 1);
    localparam logic [PW:0] MAXO = ((PW+1)'(1) << (WIDTH_OUT - 1)) - (PW+1)'(1);

    logic [WIDTH_GAIN-1:0] r_gain;
    logic [WIDTH_IN-1:0]   r_open_lvl;
    logic [WIDTH_IN-1:0]   r_close_lvl;
    logic [HANG_W-1:0]     r_hang_len;
    logic                  r_sq_en;
    logic                  w_cnt_clr;
    logic                  w_unused;

    assign w_cnt_clr = set_stb && (set_addr == A_CTRL) && set_data[CTRL_CNT_CLR];
    assign w_unused  = ^set_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gain      <= WIDTH_GAIN'(1 << GAIN_FRAC);
            r_open_lvl  <= '0;
            r_close_lvl <= '0;
            r_hang_len  <= '0;
            r_sq_en     <= 1'b0;
        end else if (set_stb) begin
            if (set_addr == A_GAIN)  r_gain      <= set_data[WIDTH_GAIN-1:0];
            if (set_addr == A_OPEN)  r_open_lvl  <= set_data[WIDTH_IN-1:0];
            if (set_addr == A_CLOSE) r_close_lvl <= set_data[WIDTH_IN-1:0];
            if (set_addr == A_HANG)  r_hang_len  <= set_data[HANG_W-1:0];
            if (set_addr == A_CTRL)  r_sq_en     <= set_data[CTRL_EN];
        end
    end

    logic r_v1, r_v2, r_v3;
    logic w_ld1, w_ld2, w_ld3, w_acc;

    assign w_ld3    = ~r_v3 | o_tready;
    assign w_ld2    = ~r_v2 | w_ld3;
    assign w_ld1    = ~r_v1 | w_ld2;
    assign w_acc    = i_tvalid & w_ld1 & ~clear;
    assign i_tready = w_ld1;
    assign o_tvalid = r_v3;

    logic w_pass, w_open_pulse;

    squelch_hang_fsm #(
        .WIDTH_IN (WIDTH_IN),
        .HANG_W   (HANG_W)
    ) u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (clear),
        .i_en         (r_sq_en),
        .i_step       (w_acc),
        .i_mag        (i_tdata),
        .i_open_lvl   (r_open_lvl),
        .i_close_lvl  (r_close_lvl),
        .i_hang_len   (r_hang_len),
        .o_pass       (w_pass),
        .o_open_pulse (w_open_pulse),
        .o_sq_open    (sq_open)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (clear) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_ld1) r_v1 <= w_acc;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld3) r_v3 <= r_v2;
        end
    end

    // Gain travels with the sample so a settings write only affects later samples.
    logic [WIDTH_IN-1:0]   r_d1;
    logic [WIDTH_GAIN-1:0] r_g1;
    logic                  r_l1;
    logic [PW-1:0]         r_p;
    logic                  r_l2;
    logic [PW:0]           w_sum;
    logic [PW:0]           w_r;
    logic [WIDTH_OUT-1:0]  w_o;

    assign w_sum = {1'b0, r_p} + HALF;
    assign w_r   = w_sum >> GAIN_FRAC;
    assign w_o   = (w_r > MAXO) ? MAXO[WIDTH_OUT-1:0] : w_r[WIDTH_OUT-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d1    <= '0;
            r_g1    <= '0;
            r_l1    <= 1'b0;
            r_p     <= '0;
            r_l2    <= 1'b0;
            o_tdata <= '0;
            o_tlast <= 1'b0;
        end else begin
            if (w_ld1 && w_acc) begin
                r_d1 <= w_pass ? i_tdata : '0;
                r_g1 <= r_gain;
                r_l1 <= i_tlast;
            end
            if (w_ld2 && r_v1) begin
                r_p  <= PW'(r_d1) * PW'(r_g1);
                r_l2 <= r_l1;
            end
            if (w_ld3 && r_v2) begin
                o_tdata <= w_o;
                o_tlast <= r_l2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_count <= '0;
        end else if (clear || w_cnt_clr) begin
            open_count <= '0;
        end else if (w_open_pulse && open_count != 16'hFFFF) begin
            open_count <= open_count + 16'd1;
        end
    end

endmodule
